// File: rtl/apb_regfile_completer.sv
`default_nettype none
// ============================================================================
//  Module   : apb_regfile_completer
//  Purpose  : APB4 completer exposing NUM_REGS read/write registers with
//             byte-strobe writes, a fixed number of wait states and error
//             responses for out-of-range, unaligned and (optionally)
//             unprivileged accesses.
//  Ports    : pclk/presetn      - clock, synchronous active-low reset
//             paddr/psel/penable/pwrite/pwdata/pstrb/pprot - APB request
//             prdata/pready/pslverr                       - APB response
//  Options  : APB_PROT_CHECK_EN - when defined, the upper half of the
//             register space requires pprot[0]=1 (privileged).
//  Revision : 1.0 - initial release
// ============================================================================
module apb_regfile_completer #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [DATA_WIDTH-1:0] pwdata,
   input  logic [STRB_WIDTH-1:0] pstrb,
   input  logic [2:0]            pprot,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int LANE_BITS = $clog2(STRB_WIDTH);
   localparam int IDX_BITS  = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH:0]   SPACE_BYTES = (ADDR_WIDTH+1)'(NUM_REGS * STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LANE_MASK   = ADDR_WIDTH'(STRB_WIDTH - 1);
   localparam logic [3:0]            WS          = 4'(WAIT_STATES);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic                  err_q, err_d;
   logic [IDX_BITS-1:0]   idx_q, idx_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] strb_q, strb_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   // Decode of the live request, only consumed in the setup cycle.
   logic [IDX_BITS-1:0]   w_in_idx;
   logic                  w_in_err;
   logic                  w_unused_prot;

   assign w_unused_prot = ^pprot;
   assign w_in_idx      = paddr[LANE_BITS +: IDX_BITS];

`ifdef APB_PROT_CHECK_EN
   // Index MSB set means the upper half, which demands a privileged access.
   assign w_in_err = ({1'b0, paddr} >= SPACE_BYTES) ||
                     ((paddr & LANE_MASK) != '0) ||
                     (w_in_idx[IDX_BITS-1] && !pprot[0]);
`else
   assign w_in_err = ({1'b0, paddr} >= SPACE_BYTES) ||
                     ((paddr & LANE_MASK) != '0);
`endif

   // Response is built one cycle early so pready/prdata/pslverr come straight
   // from flops. The selected source is the live decode when WAIT_STATES is
   // zero (response launched from the setup cycle), else the latched request.
   logic                  resp_now;
   logic                  resp_write;
   logic                  resp_err;
   logic [IDX_BITS-1:0]   resp_idx;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      write_d    = write_q;
      err_d      = err_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      strb_d     = strb_q;
      regs_d     = regs_q;
      resp_now   = 1'b0;
      resp_write = write_q;
      resp_err   = err_q;
      resp_idx   = idx_q;

      case (state_q)
         S_IDLE: begin
            if (psel && !penable) begin
               write_d = pwrite;
               wdata_d = pwdata;
               strb_d  = pstrb;
               idx_d   = w_in_idx;
               err_d   = w_in_err;
               cnt_d   = WS;
               state_d = S_ACCESS;
               if (WS == 4'd0) begin
                  resp_now   = 1'b1;
                  resp_write = pwrite;
                  resp_err   = w_in_err;
                  resp_idx   = w_in_idx;
               end
            end
         end
         S_ACCESS: begin
            if (!psel) begin
               // Dropped select mid-transfer: abandon without side effects.
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               // This is the pready cycle; the write commits on its closing edge.
               state_d = S_IDLE;
               if (write_q && !err_q) begin
                  for (int b = 0; b < STRB_WIDTH; b++) begin
                     if (strb_q[b]) begin
                        regs_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
                     end
                  end
               end
            end else begin
               cnt_d = 4'(cnt_q - 4'd1);
               if (cnt_q == 4'd1) begin
                  resp_now = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      pready_d  = resp_now;
      pslverr_d = resp_now && resp_err;
      prdata_d  = (resp_now && !resp_write && !resp_err) ? regs_q[resp_idx] : '0;
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         write_q   <= write_d;
         err_q     <= err_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         regs_q    <= regs_d;
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_completer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_regfile_completer
//  Purpose  : Self-checking bench for apb_regfile_completer. Three instances
//             (WAIT_STATES = 1, 0, 3) share the request bus, each with its
//             own psel. Expected responses come from a register model and
//             are queued when a transfer is launched, then popped and
//             compared when pready arrives.
//  Options  : APB_PROT_CHECK_EN - selects the privileged-region expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_regfile_completer;

   logic        clk = 1'b0;
   logic        presetn;
   logic [31:0] paddr;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        psel_v    [3];
   logic [31:0] prdata_v  [3];
   logic        pready_v  [3];
   logic        pslverr_v [3];

   always #5 clk = ~clk;

   apb_regfile_completer #(.WAIT_STATES(1)) u_dut_ws1 (
      .pclk(clk), .presetn(presetn), .paddr(paddr), .psel(psel_v[0]),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pprot(pprot), .prdata(prdata_v[0]), .pready(pready_v[0]),
      .pslverr(pslverr_v[0]));

   apb_regfile_completer #(.WAIT_STATES(0)) u_dut_ws0 (
      .pclk(clk), .presetn(presetn), .paddr(paddr), .psel(psel_v[1]),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pprot(pprot), .prdata(prdata_v[1]), .pready(pready_v[1]),
      .pslverr(pslverr_v[1]));

   apb_regfile_completer #(.WAIT_STATES(3)) u_dut_ws3 (
      .pclk(clk), .presetn(presetn), .paddr(paddr), .psel(psel_v[2]),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pprot(pprot), .prdata(prdata_v[2]), .pready(pready_v[2]),
      .pslverr(pslverr_v[2]));

`ifdef APB_PROT_CHECK_EN
   bit prot_en = 1'b1;
`else
   bit prot_en = 1'b0;
`endif

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
   } exp_t;

   int          total = 0;
   int          bad   = 0;
   int          ws_tab [3] = '{1, 0, 3};
   logic [31:0] model [3][16];
   exp_t        sb [$];

   task automatic model_reset();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 16; i++)
            model[d][i] = 32'h0;
   endtask

   // One complete APB transfer on instance d, scored against the model.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb,
                       input logic [2:0] prot, input string tag);
      exp_t e;
      int   idx;
      bit   err;
      int   lat;
      bit   done;
      idx   = int'(addr[5:2]);
      err   = (addr >= 32'd64) || (addr[1:0] != 2'b00) ||
              (prot_en && idx >= 8 && !prot[0]);
      e.err  = err;
      e.data = 32'h0;
      e.lat  = 1 + ws_tab[d];
      if (!err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
         end else begin
            e.data = model[d][idx];
         end
      end
      sb.push_back(e);

      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) psel_v[k] = (k == d);
      penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      pstrb = strb; pprot = prot;
      total++;
      if (pready_v[d] !== 1'b0) begin
         bad++;
         $display("FAIL %s pready-in-setup: got %b want 0", tag, pready_v[d]);
      end

      lat = 0; done = 1'b0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            // Request fields change after setup; the completer must ignore them.
            penable = 1'b1; paddr = 32'hFFFF_FFF0; pwdata = ~wd;
            pstrb = ~strb; pwrite = ~wr; pprot = ~prot;
         end
         if (pready_v[d] === 1'b1) begin
            done = 1'b1;
         end else begin
            total++;
            if (prdata_v[d] !== 32'h0 || pslverr_v[d] !== 1'b0) begin
               bad++;
               $display("FAIL %s wait-outputs: prdata=%h pslverr=%b want 0/0",
                        tag, prdata_v[d], pslverr_v[d]);
            end
         end
      end

      e = sb.pop_front();
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s timeout: pready not seen in %0d cycles want %0d", tag, lat, e.lat);
      end else begin
         total++;
         if (lat !== e.lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, e.lat);
         end
         total++;
         if (pslverr_v[d] !== e.err) begin
            bad++;
            $display("FAIL %s pslverr: got %b want %b", tag, pslverr_v[d], e.err);
         end
         total++;
         if (prdata_v[d] !== e.data) begin
            bad++;
            $display("FAIL %s prdata: got %h want %h", tag, prdata_v[d], e.data);
         end
      end
   endtask

   task automatic bus_idle();
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) psel_v[k] = 1'b0;
      penable = 1'b0;
   endtask

   task automatic test_reset();
      presetn = 1'b0;
      for (int k = 0; k < 3; k++) psel_v[k] = 1'b0;
      penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         total++;
         if (prdata_v[d] !== 32'h0 || pready_v[d] !== 1'b0 || pslverr_v[d] !== 1'b0) begin
            bad++;
            $display("FAIL reset-outputs dut%0d: prdata=%h pready=%b pslverr=%b want 0/0/0",
                     d, prdata_v[d], pready_v[d], pslverr_v[d]);
         end
      end
      model_reset();
      presetn = 1'b1;
      for (int i = 0; i < 16; i++)
         xfer(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, 3'b001, "reset-read");
      bus_idle();
   endtask

   task automatic test_strobe();
      xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'b1111, 3'b001, "strb-full");
      xfer(0, 1'b1, 32'h08, 32'h11223344, 4'b0101, 3'b001, "strb-partial");
      xfer(0, 1'b0, 32'h08, 32'h0, 4'b0000, 3'b001, "strb-read");
      xfer(0, 1'b1, 32'h08, 32'h55555555, 4'b0000, 3'b001, "strb-none");
      xfer(0, 1'b0, 32'h08, 32'h0, 4'b1111, 3'b001, "strb-none-read");
      bus_idle();
   endtask

   task automatic test_errors();
      xfer(0, 1'b1, 32'h04, 32'h12345678, 4'b1111, 3'b001, "err-preload");
      xfer(0, 1'b0, 32'h40, 32'h0, 4'b0000, 3'b001, "err-range-read");
      xfer(0, 1'b1, 32'h05, 32'hFFFFFFFF, 4'b1111, 3'b001, "err-unaligned-wr");
      xfer(0, 1'b0, 32'h04, 32'h0, 4'b0000, 3'b001, "err-after-read");
      xfer(0, 1'b0, 32'h06, 32'h0, 4'b0000, 3'b001, "err-unaligned-rd");
      bus_idle();
   endtask

   task automatic test_back_to_back();
      xfer(1, 1'b1, 32'h0C, 32'hC0FFEE01, 4'b1111, 3'b001, "b2b-ws0-wr");
      xfer(1, 1'b0, 32'h0C, 32'h0, 4'b0000, 3'b001, "b2b-ws0-rd");
      xfer(2, 1'b1, 32'h0C, 32'hC0FFEE03, 4'b1111, 3'b001, "b2b-ws3-wr");
      xfer(2, 1'b0, 32'h0C, 32'h0, 4'b0000, 3'b001, "b2b-ws3-rd");
      xfer(0, 1'b1, 32'h0C, 32'h0A0B0C0D, 4'b1100, 3'b001, "b2b-ws1-wr");
      xfer(0, 1'b0, 32'h0C, 32'h0, 4'b0000, 3'b001, "b2b-ws1-rd");
      bus_idle();
   endtask

   task automatic test_abort();
      @(posedge clk); #1;
      psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14;
      pwdata = 32'h5A5A5A5A; pstrb = 4'hF; pprot = 3'b001;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel_v[2] = 1'b0; penable = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         total++;
         if (pready_v[2] !== 1'b0) begin
            bad++;
            $display("FAIL abort-pready cycle %0d: got %b want 0", c, pready_v[2]);
         end
      end
      xfer(2, 1'b0, 32'h14, 32'h0, 4'b0000, 3'b001, "abort-read");
      bus_idle();
   endtask

   task automatic test_reset_mid_access();
      @(posedge clk); #1;
      psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
      pwdata = 32'hA5A5A5A5; pstrb = 4'hF; pprot = 3'b001;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      presetn = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            presetn = 1'b1;
            psel_v[2] = 1'b0; penable = 1'b0;
         end
         total++;
         if (pready_v[2] !== 1'b0) begin
            bad++;
            $display("FAIL rst-mid-pready cycle %0d: got %b want 0", c, pready_v[2]);
         end
      end
      model_reset();
      xfer(2, 1'b0, 32'h10, 32'h0, 4'b0000, 3'b001, "rst-mid-read");
      xfer(0, 1'b0, 32'h08, 32'h0, 4'b0000, 3'b001, "rst-mid-other");
      bus_idle();
   endtask

   task automatic test_prot();
      xfer(0, 1'b1, 32'h20, 32'h0BADF00D, 4'b1111, 3'b000, "prot-user-wr");
      xfer(0, 1'b0, 32'h20, 32'h0, 4'b0000, 3'b001, "prot-check1");
      xfer(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 3'b001, "prot-priv-wr");
      xfer(0, 1'b0, 32'h20, 32'h0, 4'b0000, 3'b001, "prot-check2");
      xfer(0, 1'b0, 32'h20, 32'h0, 4'b0000, 3'b000, "prot-user-rd");
      xfer(0, 1'b1, 32'h1C, 32'h77665544, 4'b1111, 3'b000, "prot-low-user-wr");
      xfer(0, 1'b0, 32'h1C, 32'h0, 4'b0000, 3'b000, "prot-low-user-rd");
      bus_idle();
   endtask

   initial begin
      test_reset();
      test_strobe();
      test_errors();
      test_back_to_back();
      test_abort();
      test_reset_mid_access();
      test_prot();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_regfile_completer.md
# apb_regfile_completer

APB4 completer (peripheral end) exposing a bank of NUM_REGS memory-mapped read/write registers with byte-strobe writes, programmable wait states and error responses. It connects to the peripheral-side signal set of the team's APB interface and is driven by the bridge. It is the team's reference target for bridge bring-up and for protocol-checker regression.

## Interface
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width; must be 8, 16 or 32.
- STRB_WIDTH, DATA_WIDTH/8, pstrb width.
- NUM_REGS, 16, number of registers; power of two, 2..256.
- WAIT_STATES, 1, access-phase cycles with pready low before completion; 0..15.

Ports:
- pclk, in, 1, APB clock; all logic on the rising edge.
- presetn, in, 1, reset, synchronous, active-low.
- paddr, in, ADDR_WIDTH, byte address.
- psel, in, 1, completer select.
- penable, in, 1, access phase.
- pwrite, in, 1, 1 = write, 0 = read.
- pwdata, in, DATA_WIDTH, write data.
- pstrb, in, STRB_WIDTH, write byte lanes.
- pprot, in, 3, protection; bit 0 = privileged.
- prdata, out, DATA_WIDTH, read data.
- pready, out, 1, transfer complete.
- pslverr, out, 1, error response, valid only with pready.

## Operation
- States: IDLE, ACCESS.
  - IDLE: psel=1 and penable=0 (setup cycle) → latch paddr, pwrite, pwdata, pstrb, pprot; load the wait counter with WAIT_STATES; go to ACCESS.
  - ACCESS: the counter decrements each cycle. When it reaches zero, assert pready for exactly one cycle, then return to IDLE.
  - ACCESS with psel=0 (protocol violation): abort, return to IDLE, and do not modify any register.
- Register index = paddr[log2(STRB_WIDTH) +: log2(NUM_REGS)].
- An error is flagged (pslverr=1 with pready) in any of these cases:
  - paddr ≥ NUM_REGS*STRB_WIDTH;
  - paddr low log2(STRB_WIDTH) bits nonzero (unaligned);
  - protection violation (see Configuration).
- Write without error: for each byte lane i with pstrb[i]=1, reg[idx] byte i ← pwdata byte i. Other lanes are unchanged. pstrb=0 is a legal no-op.
- Write with error: no register changes.
- Read without error: prdata = reg[idx]. pstrb is ignored on reads.
- Read with error: prdata = 0.
- prdata is 0 in every cycle where pready=0, and during writes.
- Reset values:
  - all registers 0;
  - prdata 0, pready 0, pslverr 0;
  - state IDLE.
- Reset wins over everything. A transfer in flight at reset is discarded with no write and no pready.

## Timing
- Setup cycle at cycle T. pready=1 at cycle T+1+WAIT_STATES. A transfer occupies 2+WAIT_STATES cycles.
- All outputs are registered; no combinational input-to-output path.
- A write commits on the rising edge that ends the pready cycle. A read issued in the next transfer returns the new value.
- Back-to-back: a new setup cycle is accepted in the cycle immediately after the pready cycle. There is no idle gap requirement.
- pslverr and prdata are valid in the pready cycle and are 0 in all other cycles.
- Inputs are sampled only in the setup cycle. Changes to paddr, pwdata, etc. during ACCESS have no effect.

## Configuration
- APB_PROT_CHECK_EN defined: the upper half of the register space (idx ≥ NUM_REGS/2) is privileged. Any access there with pprot[0]=0 completes with pslverr=1, no write, and prdata=0.
- APB_PROT_CHECK_EN undefined: pprot is ignored and all in-range aligned accesses succeed.

## Test plan
- Reset, then read every register: all return 0x00000000 with pslverr=0, and pready rises at T+2 (WAIT_STATES=1).
- Write 0xDEADBEEF to 0x08 with pstrb=4'b1111, then write 0x11223344 to 0x08 with pstrb=4'b0101; read 0x08 → 0xDE22BE44.
- Read 0x40 (out of range, NUM_REGS=16) → pslverr=1, prdata=0. Write 0xFFFFFFFF to 0x05 (unaligned) → pslverr=1, and a subsequent read of 0x04 is unchanged.
- WAIT_STATES=0 and then 3: measure setup-to-pready at 1 and 4 cycles respectively; back-to-back write then read of 0x0C returns the written data with no gap.
- Assert presetn=0 mid-ACCESS of a write of 0xA5A5A5A5 to 0x10: pready never asserts, and after reset a read of 0x10 → 0.
- With APB_PROT_CHECK_EN: write to 0x20 with pprot=3'b000 → pslverr=1 and no update; with pprot=3'b001 → write succeeds. Without the macro, both writes succeed.
